// File: rtl/register_file_hc_pkg.sv
// Shared encodings for the register_file_hc bank: write operations and clear-all sweep states.
package register_file_hc_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_INC   = 2'd1,
        OP_DEC   = 2'd2,
        OP_CLEAR = 2'd3
    } wr_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/register_file_hc_cell.sv
// One storage register of the bank: applies the selected write operation or a sweep clear,
// and flags when an increment/decrement rolls over.
module reg_cell_hc
    import register_file_hc_pkg::*;
#(
    parameter int DATA_SIZE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [1:0]           op,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 clear,
    output logic [DATA_SIZE-1:0] q,
    output logic                 wrap
);

    logic [DATA_SIZE-1:0] value_q, value_d;

    // Sweep clear and accepted writes never coincide, the top blocks writes while sweeping.
    always_comb begin
        value_d = value_q;
        wrap    = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (we) begin
            case (wr_op_e'(op))
                OP_LOAD:  value_d = wr_data;
                OP_INC: begin
                    value_d = value_q + DATA_SIZE'(1);
                    wrap    = &value_q;
                end
                OP_DEC: begin
                    value_d = value_q - DATA_SIZE'(1);
                    wrap    = ~|value_q;
                end
                OP_CLEAR: value_d = '0;
                default:  value_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/register_file_hc.sv
// Addressable register bank with one operation-select write port, two combinational
// read ports and a one-register-per-cycle clear-all sweep.
module register_file_hc
    import register_file_hc_pkg::*;
#(
    parameter  int DATA_SIZE = 16,
    parameter  int NUM_REGS  = 8,
    localparam int ADDR_SIZE = $clog2(NUM_REGS)
) (
`ifdef USE_POWER_PINS
    inout  wire                  vccd1,
    inout  wire                  vssd1,
`endif
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [1:0]           wr_op,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr_a,
    input  logic [ADDR_SIZE-1:0] rd_addr_b,
    output logic [DATA_SIZE-1:0] rd_data_a,
    output logic [DATA_SIZE-1:0] rd_data_b,
    input  logic                 clear_all,
    output logic                 busy,
    output logic                 wrap,
    output logic                 wr_drop
);

    localparam logic [ADDR_SIZE:0]   REG_COUNT = (ADDR_SIZE + 1)'(NUM_REGS);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(NUM_REGS - 1);

    state_e                              state_q, state_d;
    logic [ADDR_SIZE-1:0]                idx_q, idx_d;
    logic                                wrap_q, wrap_d;
    logic                                wr_drop_q, wr_drop_d;
    logic                                sweeping;
    logic                                wr_accept;
    logic [NUM_REGS-1:0][DATA_SIZE-1:0]  regs;
    logic [NUM_REGS-1:0]                 cell_we, cell_clear, cell_wrap;

    assign sweeping  = (state_q == ST_SWEEP);
    assign wr_accept = wr_en && !sweeping && ({1'b0, wr_addr} < REG_COUNT);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign cell_we[i]    = wr_accept && (wr_addr == ADDR_SIZE'(i));
        assign cell_clear[i] = sweeping && (idx_q == ADDR_SIZE'(i));

        reg_cell_hc #(
            .DATA_SIZE (DATA_SIZE)
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (cell_we[i]),
            .op      (wr_op),
            .wr_data (wr_data),
            .clear   (cell_clear[i]),
            .q       (regs[i]),
            .wrap    (cell_wrap[i])
        );
    end

    // A clear_all seen mid-sweep is ignored; the sweep always runs exactly NUM_REGS cycles.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wrap_d    = |cell_wrap;
        wr_drop_d = wr_en && !wr_accept;
        case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_SIZE'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wrap_q    <= wrap_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Out-of-range read addresses return zero rather than aliasing onto a real register.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_SIZE'(i)) rd_data_a = regs[i];
            if (rd_addr_b == ADDR_SIZE'(i)) rd_data_b = regs[i];
        end
    end

    assign busy    = sweeping;
    assign wrap    = wrap_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_register_file_hc.sv
// Bench for register_file_hc: an 8-register and a 5-register instance share one stimulus
// stream and are checked against a behavioural model through an expected-value queue.
module tb_register_file_hc;
    import register_file_hc_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] value;
    } exp_t;

    logic              clock;
    logic              reset_n;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [1:0]        wr_op;
    logic [15:0]       wr_data;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic              clear_all;
    logic [1:0][15:0]  rda;
    logic [1:0][15:0]  rdb;
    logic [1:0]        busy_o;
    logic [1:0]        wrap_o;
    logic [1:0]        drop_o;

    exp_t        sb [$];
    logic [15:0] m [2][8];
    int          nregs [2];
    int          sweep_left [2];
    int          sidx [2];
    int          checks;
    int          failures;

    register_file_hc #(.DATA_SIZE(16), .NUM_REGS(8)) dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_op     (wr_op),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rda[0]),
        .rd_data_b (rdb[0]),
        .clear_all (clear_all),
        .busy      (busy_o[0]),
        .wrap      (wrap_o[0]),
        .wr_drop   (drop_o[0])
    );

    register_file_hc #(.DATA_SIZE(16), .NUM_REGS(5)) dut5 (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_op     (wr_op),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rda[1]),
        .rd_data_b (rdb[1]),
        .clear_all (clear_all),
        .busy      (busy_o[1]),
        .wrap      (wrap_o[1]),
        .wr_drop   (drop_o[1])
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [15:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check_output(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    function automatic logic [15:0] model_read(input int j, input logic [2:0] a);
        return (int'(a) < nregs[j]) ? m[j][a] : 16'h0000;
    endfunction

    // Predict one rising edge for both instances, then compare the flag outputs after it.
    task automatic apply_stimulus(input string tag);
        for (int j = 0; j < 2; j++) begin
            logic acc, wrap_e, drop_e;
            acc    = wr_en && (sweep_left[j] == 0) && (int'(wr_addr) < nregs[j]);
            wrap_e = 1'b0;
            drop_e = wr_en && !acc;
            if (acc) begin
                case (wr_op)
                    OP_LOAD: m[j][wr_addr] = wr_data;
                    OP_INC: begin
                        wrap_e = (m[j][wr_addr] == 16'hFFFF);
                        m[j][wr_addr] = m[j][wr_addr] + 16'd1;
                    end
                    OP_DEC: begin
                        wrap_e = (m[j][wr_addr] == 16'h0000);
                        m[j][wr_addr] = m[j][wr_addr] - 16'd1;
                    end
                    default: m[j][wr_addr] = 16'h0000;
                endcase
            end
            if (sweep_left[j] > 0) begin
                m[j][sidx[j]] = 16'h0000;
                sidx[j]++;
                sweep_left[j]--;
            end else if (clear_all) begin
                sweep_left[j] = nregs[j];
                sidx[j]       = 0;
            end
            push_exp($sformatf("%s.busy%0d", tag, nregs[j]), {15'd0, sweep_left[j] > 0});
            push_exp($sformatf("%s.wrap%0d", tag, nregs[j]), {15'd0, wrap_e});
            push_exp($sformatf("%s.drop%0d", tag, nregs[j]), {15'd0, drop_e});
        end
        @(posedge clock);
        #1;
        for (int j = 0; j < 2; j++) begin
            check_output({15'd0, busy_o[j]});
            check_output({15'd0, wrap_o[j]});
            check_output({15'd0, drop_o[j]});
        end
    endtask

    task automatic check_reads(input logic [2:0] a, input logic [2:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        for (int j = 0; j < 2; j++) begin
            push_exp($sformatf("rd_a%0d_n%0d", a, nregs[j]), model_read(j, a));
            push_exp($sformatf("rd_b%0d_n%0d", b, nregs[j]), model_read(j, b));
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            check_output(rda[j]);
            check_output(rdb[j]);
        end
    endtask

    task automatic check_all_reads();
        for (int i = 0; i < 8; i++) begin
            check_reads(3'(i), 3'(7 - i));
        end
    endtask

    task automatic do_write(input logic [2:0] a, input wr_op_e op, input logic [15:0] d,
                            input string tag);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_op   = op;
        wr_data = d;
        apply_stimulus(tag);
        wr_en = 1'b0;
        check_reads(a, a);
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        wr_en     = 1'b0;
        clear_all = 1'b0;
        reset_n   = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 8; i++) m[j][i] = 16'h0000;
            sweep_left[j] = 0;
            sidx[j]       = 0;
            push_exp($sformatf("%s.busy%0d", tag, nregs[j]), 16'h0000);
            push_exp($sformatf("%s.wrap%0d", tag, nregs[j]), 16'h0000);
            push_exp($sformatf("%s.drop%0d", tag, nregs[j]), 16'h0000);
        end
        for (int j = 0; j < 2; j++) begin
            check_output({15'd0, busy_o[j]});
            check_output({15'd0, wrap_o[j]});
            check_output({15'd0, drop_o[j]});
        end
        check_all_reads();
        reset_n = 1'b1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        nregs[0]      = 8;
        nregs[1]      = 5;
        sweep_left[0] = 0;
        sweep_left[1] = 0;
        sidx[0]       = 0;
        sidx[1]       = 0;
        reset_n       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_op         = '0;
        wr_data       = '0;
        rd_addr_a     = '0;
        rd_addr_b     = '0;
        clear_all     = 1'b0;
        @(posedge clock);
        #1;
        do_reset("rst0");

        do_write(3'd3, OP_LOAD, 16'h00FF, "ld_r3");
        do_write(3'd3, OP_INC, 16'h0000, "inc_r3");
        do_write(3'd5, OP_LOAD, 16'hFFFF, "ld_r5");
        do_write(3'd5, OP_INC, 16'h0000, "inc_r5_wrap");
        apply_stimulus("wrap_end");
        do_write(3'd5, OP_DEC, 16'h0000, "dec_r5_wrap");
        apply_stimulus("wrap_end2");

        // Read of the register being written must show the old value until the edge.
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_op   = OP_LOAD;
        wr_data = 16'h1234;
        check_reads(3'd2, 3'd2);
        apply_stimulus("ld_r2");
        wr_en = 1'b0;
        check_reads(3'd2, 3'd2);

        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), OP_LOAD, 16'h1001 + 16'(i) * 16'h0111, $sformatf("fill%0d", i));
        end
        check_all_reads();

        clear_all = 1'b1;
        apply_stimulus("ca_start");
        clear_all = 1'b0;
        check_all_reads();
        for (int c = 0; c < 9; c++) begin
            if (c == 1) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_op = OP_LOAD; wr_data = 16'hBEEF;
            end
            if (c == 3) clear_all = 1'b1;
            if (c == 7) begin
                wr_en = 1'b1; wr_addr = 3'd6; wr_op = OP_LOAD; wr_data = 16'hDEAD;
            end
            if (c == 8) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_op = OP_LOAD; wr_data = 16'h5A5A;
            end
            apply_stimulus($sformatf("sweep%0d", c));
            wr_en     = 1'b0;
            clear_all = 1'b0;
            check_all_reads();
        end

        do_write(3'd6, OP_LOAD, 16'h6666, "ld_r6_range");
        check_all_reads();

        do_write(3'd7, OP_LOAD, 16'h7777, "ld_r7");
        do_write(3'd4, OP_LOAD, 16'h4444, "ld_r4");
        clear_all = 1'b1;
        apply_stimulus("ca2_start");
        clear_all = 1'b0;
        apply_stimulus("ca2_1");
        apply_stimulus("ca2_2");
        do_reset("rst_mid");
        clear_all = 1'b1;
        apply_stimulus("ca3_start");
        clear_all = 1'b0;
        for (int c = 0; c < 9; c++) begin
            apply_stimulus($sformatf("ca3_%0d", c));
        end

        do_write(3'd4, OP_DEC, 16'h0000, "dec_r4_wrap");
        do_write(3'd4, OP_CLEAR, 16'h0000, "clr_r4");

        for (int k = 0; k < 60; k++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, 7));
            wr_op     = 2'($urandom_range(0, 3));
            wr_data   = 16'($urandom);
            clear_all = ($urandom_range(0, 15) == 0);
            apply_stimulus($sformatf("rnd%0d", k));
            check_reads(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        wr_en     = 1'b0;
        clear_all = 1'b0;
        check_all_reads();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
